// File: rtl/window_fetch_ctrl.sv
// Fetch/command controller for a 3x3 window buffer: walks interior window centres
// in serpentine order, loads pixels from image memory and hands each window downstream.
module window_fetch_ctrl #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 16,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rvalid,
  input  logic [7:0]         mem_rdata,
  output logic               start_read,
  output logic               start_shift,
  output logic [1:0]         shift_direc,
  output logic [3:0]         count,
  output logic [7:0]         data_r,
  input  logic               read_done,
  input  logic               shift_done,
  output logic               window_valid,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  input  logic               window_ack,
  output logic               frame_done,
  output logic               proto_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_REQ, S_FETCH_WAIT, S_WRITE, S_PRESENT, S_SHIFT, S_DONE
  } state_t;

  localparam logic [1:0] DIR_LOAD  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [COORD_W-1:0] LP_ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] LP_COL_R    = COORD_W'(IMG_W - 2);
  localparam logic [COORD_W-1:0] LP_ROW_LAST = COORD_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0]  LP_W        = ADDR_W'(IMG_W);

  state_t               r_state, w_next_state;
  logic [COORD_W-1:0]   r_row, r_col;
  logic [3:0]           r_count;
  logic [1:0]           r_direc;
  logic                 r_move_right;
  logic [7:0]           r_pix;
  logic                 r_proto_err;

  logic [1:0]           w_roff, w_coff;
  logic [COORD_W-1:0]   w_fetch_row, w_fetch_col;
  logic [ADDR_W-1:0]    w_addr;
  logic [3:0]           w_last_count;
  logic                 w_row_end, w_last_win;
  logic [1:0]           w_next_direc;

  // Offset of the fetched pixel from the window's top-left corner (r-1, c-1).
  always_comb begin
    w_roff = 2'd0;
    w_coff = 2'd0;
    case (r_direc)
      DIR_LOAD: begin
        if (r_count < 4'd3) begin
          w_roff = 2'd0;
          w_coff = r_count[1:0];
        end else if (r_count < 4'd6) begin
          w_roff = 2'd1;
          w_coff = 2'(r_count - 4'd3);
        end else begin
          w_roff = 2'd2;
          w_coff = 2'(r_count - 4'd6);
        end
      end
      DIR_RIGHT: begin w_roff = r_count[1:0]; w_coff = 2'd2;         end
      DIR_LEFT:  begin w_roff = r_count[1:0]; w_coff = 2'd0;         end
      default:   begin w_roff = 2'd2;         w_coff = r_count[1:0]; end
    endcase
  end

  assign w_fetch_row  = r_row + COORD_W'(w_roff) - LP_ONE;
  assign w_fetch_col  = r_col + COORD_W'(w_coff) - LP_ONE;
  assign w_addr       = ADDR_W'(w_fetch_row) * LP_W + ADDR_W'(w_fetch_col);
  assign w_last_count = (r_direc == DIR_LOAD) ? 4'd8 : 4'd2;
  assign w_row_end    = r_move_right ? (r_col == LP_COL_R) : (r_col == LP_ONE);
  assign w_last_win   = w_row_end && (r_row == LP_ROW_LAST);
  assign w_next_direc = w_row_end ? DIR_DOWN : (r_move_right ? DIR_RIGHT : DIR_LEFT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    busy         = (r_state != S_IDLE);
    mem_req      = 1'b0;
    mem_addr     = '0;
    start_read   = 1'b0;
    start_shift  = 1'b0;
    shift_direc  = 2'b00;
    count        = 4'd0;
    data_r       = 8'd0;
    window_valid = 1'b0;
    win_row      = '0;
    win_col      = '0;
    frame_done   = 1'b0;
    proto_err    = r_proto_err;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_FETCH_REQ;
      S_FETCH_REQ: begin
        mem_req      = 1'b1;
        mem_addr     = w_addr;
        w_next_state = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: if (mem_rvalid) w_next_state = S_WRITE;
      S_WRITE: begin
        start_read   = 1'b1;
        shift_direc  = r_direc;
        count        = r_count;
        data_r       = r_pix;
        w_next_state = (r_count == w_last_count) ? S_PRESENT : S_FETCH_REQ;
      end
      S_PRESENT: begin
        window_valid = 1'b1;
        win_row      = r_row;
        win_col      = r_col;
        if (window_ack) w_next_state = w_last_win ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        start_shift  = 1'b1;
        shift_direc  = w_next_direc;
        w_next_state = S_FETCH_REQ;
      end
      S_DONE: begin
        frame_done   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_count      <= 4'd0;
      r_direc      <= DIR_LOAD;
      r_move_right <= 1'b0;
      r_pix        <= 8'd0;
      r_proto_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_row        <= LP_ONE;
          r_col        <= LP_ONE;
          r_count      <= 4'd0;
          r_direc      <= DIR_LOAD;
          r_move_right <= 1'b1;
          r_proto_err  <= 1'b0;
        end
        S_FETCH_WAIT: if (mem_rvalid) r_pix <= mem_rdata;
        S_WRITE: begin
          if (!read_done) r_proto_err <= 1'b1;
          if (r_count != w_last_count) r_count <= r_count + 4'd1;
        end
        S_SHIFT: begin
          if (!shift_done) r_proto_err <= 1'b1;
          r_direc <= w_next_direc;
          r_count <= 4'd0;
          case (w_next_direc)
            DIR_RIGHT: r_col <= r_col + LP_ONE;
            DIR_LEFT:  r_col <= r_col - LP_ONE;
            default: begin
              r_row        <= r_row + LP_ONE;
              r_move_right <= ~r_move_right;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Bench for window_fetch_ctrl on a 4x4 frame: random image, variable memory latency,
// a 3x3 buffer model and an expected serpentine schedule built from the scan rules.
module tb_window_fetch_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 16;
  localparam int CW = 8;

  typedef struct { int addr; int cnt; int dir; } rd_t;
  typedef struct { int r; int c; int dir; } win_t;

  logic          clk = 1'b0;
  logic          rst, start, window_ack, rd_ok;
  logic          busy, mem_req, start_read, start_shift, window_valid, frame_done, proto_err;
  logic          read_done, shift_done;
  logic          mem_rvalid = 1'b0;
  logic [7:0]    mem_rdata  = 8'd0;
  logic [AW-1:0] mem_addr;
  logic [1:0]    shift_direc;
  logic [3:0]    count;
  logic [7:0]    data_r;
  logic [CW-1:0] win_row, win_col;
  logic [63:0]   outv;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int rem     = 0;
  int p_addr  = 0;
  int err_model = 0;
  logic [7:0] img [W*H];
  logic [7:0] bm  [3][3];

  always #5 clk = ~clk;

  window_fetch_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .start_read(start_read), .start_shift(start_shift), .shift_direc(shift_direc),
    .count(count), .data_r(data_r), .read_done(read_done), .shift_done(shift_done),
    .window_valid(window_valid), .win_row(win_row), .win_col(win_col),
    .window_ack(window_ack), .frame_done(frame_done), .proto_err(proto_err)
  );

  assign read_done  = start_read & rd_ok;
  assign shift_done = start_shift;
  assign outv = {11'd0, busy, mem_req, mem_addr, start_read, start_shift, shift_direc, count,
                 data_r, window_valid, win_row, win_col, frame_done, proto_err};

  // Memory: answers each request 'lat' cycles later, even across a reset.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = 8'd0;
    if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = img[p_addr];
      end
    end
    if (mem_req === 1'b1) begin
      rem    = lat;
      p_addr = int'(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_buffer(input int r, input int c);
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        check("window_pixel", 32'(bm[a][b]), 32'(img[(r + 1 - a) * W + (c - 1 + b)]));
  endtask

  task automatic run_frame(input int L, input int max_stall, input int nack_wr, input int abort_req);
    rd_t  exp_rd[$];
    win_t wins[$];
    rd_t  e;
    int   r, c, dir, pr, pc, nk;
    bit   right;
    int   rd_idx = 0, wr_idx = 0, req_n = 0, win_idx = 0, cyc = 0, last_ref = 0, stall = 0;
    bit   outstanding = 0, presenting = 0, done_seen = 0, err_next = 0;

    // Serpentine schedule of window centres and the pixels each step loads.
    r = 1; c = 1; right = 1;
    wins.push_back('{1, 1, 0});
    while (1) begin
      if (right ? (c == W - 2) : (c == 1)) begin
        if (r == H - 2) break;
        r++; right = !right; dir = 3;
      end else begin
        c = right ? c + 1 : c - 1;
        dir = right ? 1 : 2;
      end
      wins.push_back('{r, c, dir});
    end
    foreach (wins[i]) begin
      nk = (wins[i].dir == 0) ? 9 : 3;
      for (int k = 0; k < nk; k++) begin
        case (wins[i].dir)
          0:       begin pr = wins[i].r - 1 + k / 3; pc = wins[i].c - 1 + k % 3; end
          1:       begin pr = wins[i].r - 1 + k;     pc = wins[i].c + 1;         end
          2:       begin pr = wins[i].r - 1 + k;     pc = wins[i].c - 1;         end
          default: begin pr = wins[i].r + 1;         pc = wins[i].c - 1 + k;     end
        endcase
        exp_rd.push_back('{pr * W + pc, k, wins[i].dir});
      end
    end

    lat = L;
    @(negedge clk);
    start = 1'b1;
    err_model = 0;
    while (cyc < 4000 && !done_seen) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; rd_ok = 1'b1; window_ack = 1'b0;
      check("proto_err", 32'(proto_err), 32'(err_model));
      check("busy", 32'(busy), 1);
      check("read_shift_exclusive", 32'(start_read & start_shift), 0);

      if (mem_req) begin
        check("single_outstanding", 32'(outstanding), 0);
        outstanding = 1;
        if (rd_idx < exp_rd.size()) check("mem_addr", 32'(mem_addr), exp_rd[rd_idx].addr);
        else check("extra_read", rd_idx, exp_rd.size());
        if (req_n == abort_req) begin
          rst = 1'b1;
          @(negedge clk);
          check("rst_outputs_lo", outv[31:0], 0);
          check("rst_outputs_hi", outv[63:32], 0);
          rst = 1'b0; err_model = 0;
          repeat (L + 4) begin
            @(negedge clk);
            check("idle_after_rst_lo", outv[31:0], 0);
            check("idle_after_rst_hi", outv[63:32], 0);
          end
          return;
        end
        req_n++;
      end

      if (start_read) begin
        outstanding = 0;
        if (rd_idx < exp_rd.size()) begin
          e = exp_rd[rd_idx];
          check("count", 32'(count), e.cnt);
          check("write_direc", 32'(shift_direc), e.dir);
          check("data_r", 32'(data_r), 32'(img[e.addr]));
          case (e.dir)
            0:       bm[2 - e.cnt / 3][e.cnt % 3] = data_r;
            1:       bm[2 - e.cnt][2] = data_r;
            2:       bm[2 - e.cnt][0] = data_r;
            default: bm[0][e.cnt] = data_r;
          endcase
          rd_idx++;
        end else check("extra_write", rd_idx, exp_rd.size());
        if (wr_idx == nack_wr) begin
          rd_ok = 1'b0;
          err_next = 1;
        end
        wr_idx++;
      end

      if (start_shift) begin
        if (win_idx < wins.size()) begin
          check("shift_direc", 32'(shift_direc), wins[win_idx].dir);
          for (int a = 0; a < 3; a++) begin
            case (wins[win_idx].dir)
              1: begin bm[a][0] = bm[a][1]; bm[a][1] = bm[a][2]; end
              2: begin bm[a][2] = bm[a][1]; bm[a][1] = bm[a][0]; end
              default: ;
            endcase
          end
          if (wins[win_idx].dir == 3) begin
            bm[2] = bm[1];
            bm[1] = bm[0];
          end
        end else check("extra_shift", win_idx, wins.size());
      end

      if (window_valid) begin
        if (win_idx >= wins.size()) begin
          check("extra_window", win_idx, wins.size());
          window_ack = 1'b1;
        end else begin
          if (!presenting) begin
            presenting = 1;
            check("valid_latency", cyc - last_ref, (win_idx == 0) ? 1 + 9 * (L + 2) : 2 + 3 * (L + 2));
            check("win_row", 32'(win_row), wins[win_idx].r);
            check("win_col", 32'(win_col), wins[win_idx].c);
            check_buffer(wins[win_idx].r, wins[win_idx].c);
            stall = (win_idx == 0) ? max_stall : $urandom_range(0, max_stall);
          end else begin
            check("stall_win_row", 32'(win_row), wins[win_idx].r);
            check("stall_win_col", 32'(win_col), wins[win_idx].c);
            check("stall_quiet", 32'(mem_req | start_shift), 0);
          end
          if (stall == 0) begin
            window_ack = 1'b1;
            presenting = 0;
            last_ref = cyc;
            win_idx++;
          end else stall--;
        end
      end else if (!frame_done) begin
        window_ack = ($urandom_range(0, 3) == 0);
      end

      if (frame_done) begin
        check("windows_done", win_idx, wins.size());
        check("reads_done", rd_idx, exp_rd.size());
        done_seen = 1;
      end else if (!window_valid) begin
        start = ($urandom_range(0, 15) == 0);
      end
      if (err_next) err_model = 1;
      err_next = 0;
    end
    check("frame_timeout", 32'(done_seen), 1);
    @(negedge clk);
    start = 1'b0; window_ack = 1'b0; rd_ok = 1'b1;
    check("idle_after_done_lo", 32'(outv[31:1]), 0);
    check("idle_after_done_hi", outv[63:32], 0);
    check("proto_err_after_done", 32'(proto_err), 32'(err_model));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; window_ack = 1'b0; rd_ok = 1'b1;
    foreach (img[i]) img[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("reset_outputs_lo", outv[31:0], 0);
    check("reset_outputs_hi", outv[63:32], 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs_lo", outv[31:0], 0);

    run_frame(1, 0, -1, -1);
    run_frame(4, 0, -1, -1);
    run_frame(1, 6, -1, -1);
    run_frame(1, 0, -1, 5);
    run_frame(2, 1, -1, -1);
    run_frame(1, 0, $urandom_range(0, 17), -1);
    run_frame($urandom_range(1, 5), 2, -1, -1);
    repeat (3) begin
      foreach (img[i]) img[i] = 8'($urandom);
      run_frame($urandom_range(1, 5), $urandom_range(0, 3), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
